// File: rtl/key_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_pkg : shared constants and FSM state type for the key playback decoder
// Rev 1.0
// ----------------------------------------------------------------------------
package key_pkg;

  localparam int NUM_KEYS   = 48;
  localparam int KEY_CODE_W = 6;
  localparam logic [KEY_CODE_W-1:0] REST_CODE = 6'd48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/key_playback_dec_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_playback_dec_if : note-entry valid/ready stream into the playback decoder
// Rev 1.0
// ----------------------------------------------------------------------------
interface key_playback_dec_if
  import key_pkg::*;
#(
  parameter int DUR_W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [KEY_CODE_W-1:0] in_code;
  logic [DUR_W-1:0]      in_dur;
  logic                  in_last;

  modport master (output in_valid, in_code, in_dur, in_last, input  in_ready);
  modport slave  (input  in_valid, in_code, in_dur, in_last, output in_ready);

endinterface
`default_nettype wire

// File: rtl/key_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_dec : key code to one-hot key lines; rest and out-of-range codes give zero
// Rev 1.0
// ----------------------------------------------------------------------------
module key_dec
  import key_pkg::*;
#(
  parameter int NUM_KEYS = key_pkg::NUM_KEYS
)(
  input  wire logic [KEY_CODE_W-1:0] code,
  output logic      [NUM_KEYS-1:0]   onehot,
  output logic                       invalid
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    localparam logic [KEY_CODE_W-1:0] c_idx = KEY_CODE_W'(i);
    assign onehot[i] = (code == c_idx);
  end

  assign invalid = (code > REST_CODE);

endmodule
`default_nettype wire

// File: rtl/key_playback_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_playback_dec : plays a stream of (code, duration, last) notes onto key lines
// Rev 1.0
// ----------------------------------------------------------------------------
module key_playback_dec
  import key_pkg::*;
#(
  parameter int NUM_KEYS = key_pkg::NUM_KEYS,
  parameter int DUR_W    = 8
)(
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  input  wire logic          stop,
  input  wire logic          tick,
  key_playback_dec_if.slave  in_if,
  output logic [NUM_KEYS-1:0] key,
  output logic               playing,
  output logic               done,
  output logic               err_code
);

  state_t                r_state;
  logic [KEY_CODE_W-1:0] r_code;
  logic [DUR_W-1:0]      r_dur;
  logic [DUR_W-1:0]      r_cnt;
  logic                  r_last;
  logic                  r_err;
  logic [NUM_KEYS-1:0]   r_key;

  logic [KEY_CODE_W-1:0] w_dec_code;
  logic [NUM_KEYS-1:0]   w_dec_key;
  logic                  w_dec_invalid;
  logic                  w_accept;
  logic [DUR_W-1:0]      w_cnt_end;
  logic                  w_note_end;

  // Decode the offered code while fetching, the latched code while playing.
  assign w_dec_code = (r_state == ST_FETCH) ? in_if.in_code : r_code;

  key_dec #(
    .NUM_KEYS (NUM_KEYS)
  ) u_key_dec (
    .code    (w_dec_code),
    .onehot  (w_dec_key),
    .invalid (w_dec_invalid)
  );

  assign w_accept   = (r_state == ST_FETCH) && in_if.in_valid;
  assign w_cnt_end  = (r_dur == '0) ? '0 : r_dur - DUR_W'(1);
  assign w_note_end = (r_state == ST_PLAY) && tick && (r_cnt == w_cnt_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_dur   <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_key   <= '0;
    end else if (stop) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_err   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (w_accept) begin
            r_code  <= in_if.in_code;
            r_dur   <= in_if.in_dur;
            r_last  <= in_if.in_last;
            r_cnt   <= '0;
            r_key   <= w_dec_key;
            r_state <= ST_PLAY;
            if (w_dec_invalid) r_err <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_note_end) begin
            r_key   <= '0;
            r_state <= r_last ? ST_DONE : ST_FETCH;
          end else begin
            r_key <= w_dec_key;
            if (tick) r_cnt <= r_cnt + DUR_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_key   <= '0;
        end
      endcase
    end
  end

  assign key            = r_key;
  assign err_code       = r_err;
  assign playing        = (r_state == ST_FETCH) || (r_state == ST_PLAY);
  assign done           = (r_state == ST_DONE);
  assign in_if.in_ready = (r_state == ST_FETCH);

endmodule
`default_nettype wire

// File: tb/tb_key_playback_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_playback_dec : vector table, corner sequences and random songs
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_key_playback_dec;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        tick  = 1'b0;
  logic [47:0] key;
  logic        playing;
  logic        done;
  logic        err_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  code;
    logic [7:0]  dur;
    logic        last;
    logic [47:0] exp_key;
    int          exp_ticks;
    logic        exp_err;
  } vec_t;

  vec_t tbl[13];

  key_playback_dec_if #(.DUR_W(8)) bus ();

  key_playback_dec #(
    .NUM_KEYS (48),
    .DUR_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .in_if    (bus),
    .key      (key),
    .playing  (playing),
    .done     (done),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] ref_key(input logic [5:0] code);
    logic [47:0] one;
    one = 48'h1;
    return (code < 6'd48) ? (one << code) : 48'h0;
  endfunction

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    chk("start_playing", 64'(playing), 64'd1);
    chk("start_err_clr", 64'(err_code), 64'd0);
  endtask

  // One note: offer it in FETCH, then expect the key held for exp_ticks ticks.
  task automatic play_note(input logic [5:0] code, input logic [7:0] dur, input logic last,
                           input logic [47:0] exp_key, input int exp_ticks, input logic exp_err);
    int ticks;
    int guard;
    chk("fetch_ready", 64'(bus.in_ready), 64'd1);
    chk("fetch_gap_key", 64'(key), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_dur   = dur;
    bus.in_last  = last;
    tick = 1'($urandom_range(0, 1));
    cyc();
    bus.in_valid = 1'b0;
    tick  = 1'b0;
    chk("accept_err", 64'(err_code), 64'(exp_err));
    ticks = 0;
    guard = 0;
    while (ticks < exp_ticks && guard < 5000) begin
      chk("note_key", 64'(key), 64'(exp_key));
      chk("note_playing", 64'(playing), 64'd1);
      tick = ($urandom_range(0, 2) == 0);
      if (tick) ticks++;
      guard++;
      cyc();
    end
    tick = 1'b0;
    chk("note_tick_budget", 64'(ticks), 64'(exp_ticks));
    chk("release_key", 64'(key), 64'd0);
    if (last) begin
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_playing", 64'(playing), 64'd0);
      cyc();
      chk("done_single", 64'(done), 64'd0);
      chk("idle_ready", 64'(bus.in_ready), 64'd0);
      chk("idle_err_sticky", 64'(err_code), 64'(exp_err));
    end else begin
      chk("next_fetch", 64'(bus.in_ready), 64'd1);
      chk("next_no_done", 64'(done), 64'd0);
    end
  endtask

  initial begin
    logic new_song;
    logic model_err;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.in_dur   = '0;
    bus.in_last  = 1'b0;

    repeat (2) cyc();
    chk("rst_key", 64'(key), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_playing", 64'(playing), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_wait", 64'(bus.in_ready), 64'd0);

    // Stop beats start in the same cycle.
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_wins_ready", 64'(bus.in_ready), 64'd0);
    chk("stop_wins_playing", 64'(playing), 64'd0);

    tbl[0]  = '{6'd5,  8'd3,   1'b0, 48'h0000_0000_0020, 3,   1'b0};
    tbl[1]  = '{6'd48, 8'd2,   1'b0, 48'h0000_0000_0000, 2,   1'b0};
    tbl[2]  = '{6'd47, 8'd1,   1'b1, 48'h8000_0000_0000, 1,   1'b0};
    tbl[3]  = '{6'd10, 8'd0,   1'b1, 48'h0000_0000_0400, 1,   1'b0};
    tbl[4]  = '{6'd55, 8'd2,   1'b0, 48'h0000_0000_0000, 2,   1'b1};
    tbl[5]  = '{6'd0,  8'd1,   1'b1, 48'h0000_0000_0001, 1,   1'b1};
    tbl[6]  = '{6'd63, 8'd4,   1'b0, 48'h0000_0000_0000, 4,   1'b1};
    tbl[7]  = '{6'd49, 8'd0,   1'b0, 48'h0000_0000_0000, 1,   1'b1};
    tbl[8]  = '{6'd31, 8'd2,   1'b1, 48'h0000_8000_0000, 2,   1'b1};
    tbl[9]  = '{6'd1,  8'd255, 1'b1, 48'h0000_0000_0002, 255, 1'b0};
    tbl[10] = '{6'd46, 8'd1,   1'b0, 48'h4000_0000_0000, 1,   1'b0};
    tbl[11] = '{6'd48, 8'd0,   1'b0, 48'h0000_0000_0000, 1,   1'b0};
    tbl[12] = '{6'd12, 8'd2,   1'b1, 48'h0000_0000_1000, 2,   1'b0};

    new_song = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (new_song) do_start();
      play_note(tbl[i].code, tbl[i].dur, tbl[i].last, tbl[i].exp_key,
                tbl[i].exp_ticks, tbl[i].exp_err);
      new_song = tbl[i].last;
    end

    // FETCH with nothing offered: ticks must not advance anything.
    do_start();
    for (int i = 0; i < 10; i++) begin
      tick = i[0];
      cyc();
      chk("stall_ready", 64'(bus.in_ready), 64'd1);
      chk("stall_key", 64'(key), 64'd0);
    end
    tick = 1'b0;
    play_note(6'd12, 8'd2, 1'b1, 48'h0000_0000_1000, 2, 1'b0);

    // Stop mid-note, then replay.
    do_start();
    bus.in_valid = 1'b1;
    bus.in_code  = 6'd20;
    bus.in_dur   = 8'd5;
    bus.in_last  = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("pre_stop_key", 64'(key), 64'h0000_0010_0000);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_key", 64'(key), 64'd0);
    chk("stop_playing", 64'(playing), 64'd0);
    chk("stop_done", 64'(done), 64'd0);
    chk("stop_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    chk("stop_no_done", 64'(done), 64'd0);
    do_start();
    play_note(6'd20, 8'd1, 1'b1, 48'h0000_0010_0000, 1, 1'b0);

    // Start ignored while playing, then asynchronous reset mid-note.
    do_start();
    bus.in_valid = 1'b1;
    bus.in_code  = 6'd3;
    bus.in_dur   = 8'd4;
    bus.in_last  = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored_key", 64'(key), 64'h8);
    chk("start_ignored_ready", 64'(bus.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_key", 64'(key), 64'd0);
    chk("async_playing", 64'(playing), 64'd0);
    chk("async_ready", 64'(bus.in_ready), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_err", 64'(err_code), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 64'(bus.in_ready), 64'd0);
    chk("post_rst_key", 64'(key), 64'd0);

    // Random songs against the note-level model.
    for (int s = 0; s < 25; s++) begin
      int n;
      do_start();
      model_err = 1'b0;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        logic [5:0] code;
        logic [7:0] dur;
        code = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(49, 63)) : 6'($urandom_range(0, 48));
        dur  = 8'($urandom_range(0, 6));
        if (code > 6'd48) model_err = 1'b1;
        play_note(code, dur, (k == n - 1), ref_key(code), (dur == 8'd0) ? 1 : int'(dur), model_err);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_playback_dec.md
KEY_PLAYBACK_DEC -- requirements
Module: key_playback_dec

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 48, number of key lines driven.
REQ-002 SHALL have parameter DUR_W, default 8, width of note duration in ticks.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  pulse; begins playback from IDLE.
REQ-006 SHALL have port stop  input  1  pulse; aborts playback from any state.
REQ-007 SHALL have port tick  input  1  one-cycle tempo pulse; duration time base.
REQ-008 SHALL have port in_valid  input  1  note entry offered.
REQ-009 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-010 SHALL have port in_code  input  6  key code: 0..47 key index, 48 rest, 49..63 invalid.
REQ-011 SHALL have port in_dur  input  DUR_W  note length in ticks.
REQ-012 SHALL have port in_last  input  1  entry is the final note of the song.
REQ-013 SHALL have port key  output  NUM_KEYS  one-hot (or all-zero) key drive, registered.
REQ-014 SHALL have port playing  output  1  high in FETCH and PLAY.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have port err_code  output  1  sticky flag: an invalid code was accepted.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, PLAY, DONE.
REQ-018 IDLE: key=0, in_ready=0; start -> FETCH next cycle; start outside IDLE ignored.
REQ-019 FETCH: in_ready=1, key=0 (re-articulation gap); handshake = in_valid & in_ready -> latch code/dur/last, clear tick counter, go PLAY.
REQ-020 key SHALL equal decode(latched code) from the cycle after acceptance (latency 1) until PLAY exits.
REQ-021 decode: code 0..47 -> bit[code] set only; code 48 -> all zero; 49..63 -> all zero and err_code set.
REQ-022 PLAY: tick counter increments on each tick; when tick arrives with counter == max(dur,1)-1, exit PLAY.
REQ-023 in_dur == 0 SHALL be played as 1 tick.
REQ-024 tick coincident with the acceptance cycle SHALL NOT be counted.
REQ-025 PLAY exit: in_last latched -> DONE; otherwise -> FETCH.
REQ-026 DONE: key=0, done=1 for exactly one cycle, then IDLE.
REQ-027 stop in any state -> IDLE next cycle, key=0, no done pulse; stop and start in same cycle: stop wins.
REQ-028 err_code SHALL clear only on reset or on an accepted start.
REQ-029 counter SHALL be DUR_W bits and SHALL never wrap during a note.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, key=0, in_ready=0, playing=0, done=0, err_code=0, counter=0, latched entry=0.
REQ-031 Reset assertion mid-note SHALL drop key immediately; release resumes in IDLE awaiting start.

Structure
REQ-032 Shared package key_pkg SHALL hold NUM_KEYS=48, KEY_CODE_W=6, REST_CODE=48 and the FSM state enum.
REQ-033 SHALL instantiate one combinational sub-module key_dec (6-bit code -> NUM_KEYS one-hot, codes >=48 -> zero, plus invalid flag), the inverse of the existing key encoder.

Verification
REQ-034 start; entries (5,3,0),(48,2,0),(47,1,1); tick every 4 cycles -> key=bit5 for 3 ticks, zero 2 ticks, bit47 1 tick, single done pulse, playing falls.
REQ-035 Entry (10,0,1) -> bit10 held exactly one tick, then done.
REQ-036 Entry code 55 dur 2 -> key all zero for 2 ticks, err_code=1 and remains set until next start.
REQ-037 stop asserted mid-PLAY on code 20 -> key=0 and IDLE next cycle, no done; subsequent start replays from FETCH.
REQ-038 in_valid held low in FETCH for 10 cycles with ticks -> key=0, in_ready=1, state unchanged; counter unchanged.
REQ-039 rst_n pulsed low asynchronously while key=bit3 -> key=0 before next clk edge; all outputs at reset values.
